// File: rtl/keyboard_controller.sv
// Generic synchronous FIFO with same-cycle push/pop and a drop strobe on overflow.
// Latency: a pushed entry is visible at rd_dat the cycle after the push edge.
// Backpressure: none upstream; a push into a full FIFO without a pop is dropped and flagged.
module kbd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    wr_vld,
    input  logic [WIDTH-1:0]        wr_dat,
    input  logic                    rd_rdy,
    output logic [WIDTH-1:0]        rd_dat,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    nonempty,
    output logic                    wr_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = rd_rdy && (count != '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push  = wr_vld && (!full || do_pop);
    assign wr_drop  = wr_vld && !do_push;
    assign rd_dat   = mem[rd_ptr];

    always_comb begin
        count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            nonempty <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nxt;
            nonempty <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Memory-mapped PS/2 keyboard receiver: filters the pins, deframes scan codes, queues them for the CPU.
// Latency: code pushed on the stop-bit strike; register reads return one cycle after the address.
// Backpressure: none toward the keyboard; codes arriving while the FIFO is full are dropped and flagged.
module keyboard_controller #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    input  logic [31:0] cpu_addr_in,
    input  logic [31:0] cpu_data_in,
    input  logic [3:0]  cpu_write_enable_in,
    output logic [31:0] cpu_data_out,
    output logic        nonempty_out
);
    localparam int FW = $clog2(FILTER_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt, filt_d;
    logic [FW-1:0] fcnt;
    logic          strike;

    rx_state_t     state, state_nxt;
    logic [7:0]    shift_r;
    logic          par_r;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          timeout;

    logic          push_vld, par_err_evt, frm_err_evt, shift_en, par_en;
    logic          frame_ok;

    logic [7:0]    head_dat;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_nonempty, fifo_drop;

    logic          ctrl_wr, pop_req, clr_req;
    logic          ovf_r, par_err_r, frm_err_r;
    logic [31:0]   status, rd_mux;
    logic          unused_ok;

    assign unused_ok = ^{cpu_addr_in[31:4], cpu_addr_in[1:0], cpu_data_in[31:2],
                         cpu_write_enable_in[3:1]};

    // Pin conditioning: 2-flop synchronisers, then a run-length glitch filter on the clock.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            filt    <= 1'b1;
            filt_d  <= 1'b1;
            fcnt    <= '0;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
            filt_d  <= filt;
            if (clk_s2 != filt) begin
                if (fcnt == FW'(FILTER_CYCLES - 1)) begin
                    filt <= ~filt;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end else begin
                fcnt <= '0;
            end
        end
    end

    assign strike  = filt_d && !filt;
    assign timeout = (state != IDLE) && !strike && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (strike && !data_s2)           state_nxt = DATA;
            DATA:    if (strike && bit_cnt == 3'd7)    state_nxt = PARITY;
            PARITY:  if (strike)                       state_nxt = STOP;
            STOP:    if (strike)                       state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    always_comb begin
        // Odd parity over data plus parity bit.
        frame_ok    = data_s2 && (^{shift_r, par_r});
        shift_en    = (state == DATA)   && strike;
        par_en      = (state == PARITY) && strike;
        push_vld    = (state == STOP)   && strike && frame_ok;
        frm_err_evt = (state == STOP)   && strike && !data_s2;
        par_err_evt = (state == STOP)   && strike && data_s2 && !(^{shift_r, par_r});
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_r <= '0;
            par_r   <= 1'b0;
            bit_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == IDLE)  bit_cnt <= '0;
            else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)       shift_r <= {data_s2, shift_r[7:1]};
            if (par_en)         par_r   <= data_s2;
            if (strike || state == IDLE) tmo_cnt <= '0;
            else                         tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign ctrl_wr = cpu_write_enable_in[0] && (cpu_addr_in[3:2] == 2'd2);
    assign pop_req = ctrl_wr && cpu_data_in[0];
    assign clr_req = ctrl_wr && cpu_data_in[1];

    kbd_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .wr_vld   (push_vld),
        .wr_dat   (shift_r),
        .rd_rdy   (pop_req),
        .rd_dat   (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .nonempty (fifo_nonempty),
        .wr_drop  (fifo_drop)
    );

    // A fresh error event outranks a clear landing on the same edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ovf_r     <= 1'b0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            ovf_r     <= (ovf_r     && !clr_req) || fifo_drop;
            par_err_r <= (par_err_r && !clr_req) || par_err_evt;
            frm_err_r <= (frm_err_r && !clr_req) || frm_err_evt;
        end
    end

    always_comb begin
        status = {19'b0, 5'(fifo_count), 3'b0, frm_err_r, par_err_r, ovf_r, fifo_full, fifo_nonempty};
        case (cpu_addr_in[3:2])
            2'd0:    rd_mux = status;
            2'd1:    rd_mux = fifo_nonempty ? {24'b0, head_dat} : 32'b0;
            default: rd_mux = 32'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) cpu_data_out <= '0;
        else        cpu_data_out <= rd_mux;
    end

    assign nonempty_out = fifo_nonempty;
endmodule

// File: doc/keyboard_controller.md
Name: keyboard_controller

Overview:
Memory-mapped PS/2 keyboard receiver. It is the responder on the memory controller's keyboard port (addr/data/write_enable in, data out). It deserialises PS/2 frames from the keyboard pins into scan-code bytes and buffers them in a FIFO. The CPU reads status and scan codes, and pops codes with a register write. Runs entirely in the CPU clock domain (100 MHz).

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries; must be a power of 2, 2..16.
FILTER_CYCLES, 8, consecutive equal samples required before the filtered PS/2 clock changes.
TIMEOUT_CYCLES, 100000, idle cycles mid-frame (no falling edge) before the frame is aborted.

Ports:
clk_in  input  1  CPU clock.
rst_in  input  1  Reset; synchronous to clk_in, active-high.
ps2_clk_in  input  1  Asynchronous PS/2 clock pin.
ps2_data_in  input  1  Asynchronous PS/2 data pin.
cpu_addr_in  input  32  Bus byte address; only [3:2] is decoded.
cpu_data_in  input  32  Bus write data.
cpu_write_enable_in  input  4  Byte write enables; a write occurs when any bit is set.
cpu_data_out  output  32  Registered read data.
nonempty_out  output  1  High while the FIFO holds at least 1 code.

Behaviour:
- Reset: FIFO empty (count 0), sticky errors cleared, receiver IDLE, cpu_data_out=0, nonempty_out=0. Synchroniser and filter state preset to 1.
- Input conditioning:
  - Both pins pass through 2-flop synchronisers.
  - The filtered clock flips only after FILTER_CYCLES consecutive samples opposite to its current value.
  - A falling edge of the filtered clock produces a 1-cycle sample strike; data is taken from the synchronised data line on that cycle.
- Receiver FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: on strike with data=0, go to DATA with bit counter 0. Strike with data=1 is ignored.
  - DATA: shift LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the bit; go to STOP.
  - STOP: on strike, the frame is valid if stop=1 and the 9 bits (data+parity) have an odd number of ones.
    - Valid: push the byte.
    - Parity wrong: set parity_err and discard.
    - Stop=0: set frame_err and discard.
    - In all cases return to IDLE.
  - Timeout counter resets on every strike. In any state except IDLE, reaching TIMEOUT_CYCLES returns to IDLE with no push and no error flag.
- FIFO:
  - Push on the STOP-valid cycle.
  - Push while full: byte dropped, overflow set.
  - Pop while empty: no effect.
  - Push and pop on the same cycle: both performed, count unchanged (legal even when full).
  - Pointers wrap modulo FIFO_DEPTH.
- Register map (by addr[3:2]):
  - 0 STATUS (read):
    - bit0 nonempty
    - bit1 full
    - bit2 overflow
    - bit3 parity_err
    - bit4 frame_err
    - bits[12:8] count
    - others 0
  - 1 DATA (read): {24'b0, head byte}; 0 when empty. Reads have no side effects.
  - 2 CTRL (write only; reads return 0):
    - Write with cpu_write_enable_in[0]=1: data bit0=1 pops one entry; bit1=1 clears overflow, parity_err and frame_err.
    - Both bits may be set in the same write.
  - 3 reserved: reads 0, writes ignored.
  - Writes to STATUS and DATA are ignored.
  - A write to CTRL whose enables exclude byte 0 is ignored.
- Read latency:
  - cpu_data_out is registered and reflects cpu_addr_in from the previous cycle, showing state as of that edge.
  - A pop at cycle N is visible in reads launched at N+1.
  - When an error clear coincides with a new error event, the new event wins (the flag stays set).
- nonempty_out = (count != 0), registered alongside count.
- rst_in asserted mid-frame: the frame is lost and the FIFO is emptied.

Test Plan:
- Reset then read STATUS -> 0x00000000. Read DATA -> 0x00000000. nonempty_out=0.
- Drive a valid frame for 0x1C (odd-parity bit 0, stop 1) at a 12.5 us bit period:
  - STATUS reads 0x101.
  - DATA reads 0x0000001C.
  - Write 0x1 to CTRL, then STATUS reads 0x0.
- Same frame with the parity bit flipped -> no push; STATUS=0x008. Write 0x2 to CTRL -> STATUS=0x000.
- Send 9 valid frames 0x01..0x09 with no pops -> STATUS=0x807 (count 8, full, overflow, nonempty). Popping 8 times returns 0x01..0x08 in order; 0x09 is lost.
- Send a start bit plus 3 data bits, then hold clk high for TIMEOUT_CYCLES+10. Then send a valid frame 0xF0 -> only 0xF0 is queued, with no error flags set.
- FIFO full; pop on the same cycle the STOP strike pushes 0x5A -> count stays 8, overflow=0, and 0x5A is read at the tail after 7 more pops. Separately, a 3-cycle glitch on the PS/2 clock causes no strike.
